// File: rtl/global_types_pkg.sv
// Shared types and constants for the MAC transmit path.
package global_types;

  localparam int AVST_DATA_W  = 32;
  localparam int AVST_EMPTY_W = 2;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  // Add a small beat count to a 16-bit counter, clamping at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/tx_pkt_arbiter_rr_pick.sv
// Round-robin pick: first set request bit searching last+1, last+2, ... wrapping to last.
module rr_pick #(
  parameter  int N     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    int p;
    // NOTE: every output gets a default before the search so no latch is inferred.
    found_o = 1'b0;
    idx_o   = '0;
    p       = 0;
    // Scan farthest-to-nearest so the closest request after last overrides the rest.
    for (int k = N; k >= 1; k--) begin
      p = (int'(last_i) + k) % N;
      if (req_i[IDX_W'(p)]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter onto the single TSE transmit port; flushes orphan beats.
module tx_pkt_arbiter import global_types::*; #(
  parameter  int N       = 2,
  parameter  int DATA_W  = AVST_DATA_W,
  parameter  int EMPTY_W = AVST_EMPTY_W,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic                 sys_clk,
  input  logic                 core_reset_n,
  input  logic [N*DATA_W-1:0]  in_data,
  input  logic [N-1:0]         in_sop,
  input  logic [N-1:0]         in_eop,
  input  logic [N*EMPTY_W-1:0] in_empty,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [EMPTY_W-1:0]   out_empty,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 busy,
  output logic [15:0]          drop_cnt
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [N-1:0]     flush;
  logic [3:0]       drop_pop;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(.N(N)) u_pick (
    .req_i   (in_valid & in_sop),
    .last_i  (last_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    out_data   = '0;
    out_sop    = 1'b0;
    out_eop    = 1'b0;
    out_empty  = '0;
    out_valid  = 1'b0;
    in_ready   = '0;
    flush      = '0;
    drop_pop   = '0;
    // Reset is folded in here so the combinational ready/flush path also drops at once.
    if (core_reset_n) begin
      for (int i = 0; i < N; i++) begin
        if (!(state_q == ARB_GRANT && grant_q == IDX_W'(i)) && in_valid[i] && !in_sop[i]) begin
          flush[i] = 1'b1;
        end
        drop_pop = drop_pop + 4'(flush[i]);
      end
      in_ready = flush;
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_d = pick_idx;
            state_d = ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          out_data          = in_data[int'(grant_q)*DATA_W +: DATA_W];
          out_empty         = in_empty[int'(grant_q)*EMPTY_W +: EMPTY_W];
          out_sop           = in_sop[grant_q];
          out_eop           = in_eop[grant_q];
          out_valid         = in_valid[grant_q];
          in_ready[grant_q] = out_ready;
          if (out_valid && out_ready && out_eop) begin
            state_d = ARB_IDLE;
            last_d  = grant_q;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
    drop_cnt_d = sat_add16(drop_cnt_q, drop_pop);
  end

  always_ff @(posedge sys_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      last_q     <= IDX_W'(N - 1);
      drop_cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all update together at the edge.
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == ARB_GRANT);
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Directed bench for tx_pkt_arbiter: per-port source queues, per-port expected-beat scoreboard.
module tb_tx_pkt_arbiter;
  import global_types::*;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int EW = 2;

  logic              sys_clk = 1'b0;
  logic              core_reset_n;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      in_sop, in_eop, in_valid, in_ready;
  logic [N*EW-1:0]   in_empty;
  logic [DW-1:0]     out_data;
  logic              out_sop, out_eop, out_valid, out_ready;
  logic [EW-1:0]     out_empty;
  logic [0:0]        grant_id;
  logic              busy;
  logic [15:0]       drop_cnt;

  always #5 sys_clk = ~sys_clk;

  tx_pkt_arbiter #(.N(N), .DATA_W(DW), .EMPTY_W(EW)) dut (
    .sys_clk      (sys_clk),
    .core_reset_n (core_reset_n),
    .in_data      (in_data),
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .in_empty     (in_empty),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_empty    (out_empty),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .grant_id     (grant_id),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  beat_t src0[$], src1[$], exp0[$], exp1[$];
  int    order_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    out_beats = 0;
  bit    rand_ready = 1'b0;

  logic [N-1:0] snap_rdy, snap_vld;
  logic         snap_out_valid, snap_busy;
  logic [0:0]   snap_grant;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int port, input int len, input logic [31:0] base,
                          input logic [1:0] last_empty, input bit with_sop);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = base + 32'(i);
      b.sop   = with_sop && (i == 0);
      b.eop   = with_sop && (i == len - 1);
      b.empty = b.eop ? last_empty : 2'd0;
      if (port == 0) src0.push_back(b); else src1.push_back(b);
      if (with_sop) begin
        if (port == 0) exp0.push_back(b); else exp1.push_back(b);
      end
    end
  endtask

  task automatic drive();
    beat_t b;
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0;
    if (src0.size() > 0) begin
      b = src0[0];
      in_valid[0] = 1'b1; in_sop[0] = b.sop; in_eop[0] = b.eop;
      in_data[0 +: DW] = b.data; in_empty[0 +: EW] = b.empty;
    end
    if (src1.size() > 0) begin
      b = src1[0];
      in_valid[1] = 1'b1; in_sop[1] = b.sop; in_eop[1] = b.eop;
      in_data[DW +: DW] = b.data; in_empty[EW +: EW] = b.empty;
    end
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic observe();
    beat_t got, exp;
    int    qsize;
    snap_rdy       = in_ready;
    snap_vld       = in_valid;
    snap_out_valid = out_valid;
    snap_busy      = busy;
    snap_grant     = grant_id;
    if (busy) check("ready_follow", 64'(in_ready[grant_id]), 64'(out_ready));
    if (out_valid && out_ready) begin
      out_beats++;
      got   = '{data: out_data, sop: out_sop, eop: out_eop, empty: out_empty};
      qsize = (grant_id == 1'b0) ? exp0.size() : exp1.size();
      check("beat_expected", 64'(qsize > 0), 64'(1));
      if (qsize > 0) begin
        exp = (grant_id == 1'b0) ? exp0.pop_front() : exp1.pop_front();
        check("beat_content", 64'(got), 64'(exp));
      end
      if (out_sop) order_q.push_back(int'(grant_id));
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
    drive();
    #1;
    observe();
    @(posedge sys_clk);
    if (snap_vld[0] && snap_rdy[0]) void'(src0.pop_front());
    if (snap_vld[1] && snap_rdy[1]) void'(src1.pop_front());
  endtask

  task automatic drain(input string tag, input int budget, output int cycles);
    cycles = 0;
    while ((src0.size() + src1.size() + exp0.size() + exp1.size()) > 0 && cycles < budget) begin
      step();
      cycles++;
    end
    check({tag, "_drained"}, 64'(src0.size() + src1.size() + exp0.size() + exp1.size()), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    core_reset_n = 1'b0;
    src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
    drive();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    core_reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int beats0;
    int exp_order[5];

    core_reset_n = 1'b0;
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_grant",     64'(grant_id),  64'(0));
    check("rst_drop",      64'(drop_cnt),  64'(0));
    check("rst_out_data",  64'(out_data),  64'(0));
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    core_reset_n = 1'b1;

    // Single 3-beat packet on port 0.
    push_pkt(0, 3, 32'hA0, 2'd2, 1'b1);
    step();
    check("t1_sop_cycle_valid", 64'(snap_out_valid), 64'(0));
    check("t1_sop_cycle_busy",  64'(snap_busy),      64'(0));
    step();
    check("t1_next_valid", 64'(snap_out_valid), 64'(1));
    check("t1_grant",      64'(snap_grant),     64'(0));
    step();
    step();
    check("t1_beats", 64'(out_beats), 64'(3));
    check("t1_exp_empty", 64'(exp0.size()), 64'(0));
    step();
    check("t1_gap_busy", 64'(snap_busy), 64'(0));

    // Simultaneous sops after reset: port 0, gap, port 1.
    do_reset();
    order_q.delete();
    push_pkt(0, 2, 32'hB0, 2'd0, 1'b1);
    push_pkt(1, 2, 32'hC0, 2'd1, 1'b1);
    drain("t2", 50, cyc);
    check("t2_cycles",  64'(cyc), 64'(6));
    check("t2_npkts",   64'(order_q.size()), 64'(2));
    if (order_q.size() == 2) begin
      check("t2_first",  64'(order_q[0]), 64'(0));
      check("t2_second", 64'(order_q[1]), 64'(1));
    end

    // Port 0 streams 4 packets while port 1 waits.
    order_q.delete();
    exp_order = '{0, 1, 0, 0, 0};
    push_pkt(1, 2, 32'hD0, 2'd3, 1'b1);
    for (int p = 0; p < 4; p++) push_pkt(0, 2, 32'hE0 + 32'(2 * p), 2'd0, 1'b1);
    drain("t3", 100, cyc);
    check("t3_npkts", 64'(order_q.size()), 64'(5));
    for (int i = 0; i < 5 && i < order_q.size(); i++) check("t3_order", 64'(order_q[i]), 64'(exp_order[i]));

    // Random back-pressure across a 6-beat packet.
    beats0 = out_beats;
    rand_ready = 1'b1;
    push_pkt(0, 6, 32'hF0, 2'd1, 1'b1);
    drain("t4", 300, cyc);
    rand_ready = 1'b0;
    check("t4_beats", 64'(out_beats - beats0), 64'(6));

    // Orphan beats on port 1 while idle.
    check("t5_drop_before", 64'(drop_cnt), 64'(0));
    push_pkt(1, 2, 32'h50, 2'd0, 1'b0);
    step();
    check("t5_rdy_a",   64'(snap_rdy[1]),    64'(1));
    check("t5_valid_a", 64'(snap_out_valid), 64'(0));
    step();
    check("t5_rdy_b",   64'(snap_rdy[1]),    64'(1));
    check("t5_valid_b", 64'(snap_out_valid), 64'(0));
    #1;
    check("t5_drop", 64'(drop_cnt), 64'(2));
    order_q.delete();
    push_pkt(1, 3, 32'h70, 2'd2, 1'b1);
    drain("t5", 50, cyc);
    check("t5_npkts", 64'(order_q.size()), 64'(1));
    if (order_q.size() == 1) check("t5_port", 64'(order_q[0]), 64'(1));

    // Reset at the second beat of a port 1 packet.
    push_pkt(1, 4, 32'h60, 2'd0, 1'b1);
    step();
    step();
    @(negedge sys_clk);
    drive();
    #1;
    core_reset_n = 1'b0;
    #1;
    check("t6_out_valid", 64'(out_valid), 64'(0));
    check("t6_out_sop",   64'(out_sop),   64'(0));
    check("t6_out_eop",   64'(out_eop),   64'(0));
    check("t6_out_data",  64'(out_data),  64'(0));
    check("t6_out_empty", 64'(out_empty), 64'(0));
    check("t6_in_ready",  64'(in_ready),  64'(0));
    check("t6_busy",      64'(busy),      64'(0));
    check("t6_grant",     64'(grant_id),  64'(0));
    check("t6_drop",      64'(drop_cnt),  64'(0));
    src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
    drive();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    core_reset_n = 1'b1;
    order_q.delete();
    push_pkt(0, 2, 32'h80, 2'd0, 1'b1);
    push_pkt(1, 2, 32'h90, 2'd0, 1'b1);
    drain("t6", 50, cyc);
    check("t6_npkts", 64'(order_q.size()), 64'(2));
    if (order_q.size() == 2) begin
      check("t6_first",  64'(order_q[0]), 64'(0));
      check("t6_second", 64'(order_q[1]), 64'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
